// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fifo_pkg
// Description : Shared sizing, types and pointer helper for the FIFO read-side
//               prefetch stream adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int PREFETCH_DEPTH = 3;
  localparam int PTR_W          = 2;

  typedef logic [1:0]       occ_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Circular pointer increment over PREFETCH_DEPTH entries (0,1,2,0,...)
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(PREFETCH_DEPTH - 1)) begin
      return '0;
    end
    return p + ptr_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_prefetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : fifo_prefetch_buf
// Description : 3-entry circular prefetch store with push/pop and occupancy.
//               Head word and valid are driven purely from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_prefetch_buf
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output occ_t              occ,
  output logic              valid,
  output logic [DWIDTH-1:0] data
);

  logic [DWIDTH-1:0] mem [PREFETCH_DEPTH];
  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  logic              do_pop;

  // A pop on an empty store is ignored so occ can never underflow
  assign do_pop = pop & (occ != occ_t'(0));
  assign valid  = (occ != occ_t'(0));

  // Storage, pointers and occupancy; reset clears the entries so data reads 0
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      for (int i = 0; i < PREFETCH_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      for (int i = 0; i < PREFETCH_DEPTH; i++) begin
        if (push && (wr_ptr == ptr_t'(i))) begin
          mem[i] <= push_data;
        end
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, do_pop})
        2'b10:   occ <= occ + occ_t'(1);
        2'b01:   occ <= occ - occ_t'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Head-of-buffer select; pointer value 3 is unreachable
  always_comb begin
    case (rd_ptr)
      2'd0:    data = mem[0];
      2'd1:    data = mem[1];
      default: data = mem[2];
    endcase
  end

  // The request throttle in the parent keeps pushes away from a full store
  push_into_full: assert property (@(posedge clk) disable iff (!srst_n)
                                   !(push && (occ == occ_t'(PREFETCH_DEPTH))));

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream_adapter
// Description : Turns the FIFO request/empty read port (1-cycle registered RAM
//               latency) into a valid/ready stream through a 3-entry prefetch
//               buffer. fifo_rd_req_o depends only on registers, empty and
//               reset, never on ready_i.
//               Optional macro FIFO_RD_STREAM_STATS_EN adds beat_cnt_o and
//               stall_cnt_o statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH-1:0] fifo_usedw_i,
  input  logic [DWIDTH-1:0] fifo_data_i,
  output logic              fifo_rd_req_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH:0]   level_o
`ifdef FIFO_RD_STREAM_STATS_EN
 ,output logic [31:0]       beat_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int LW = AWIDTH + 1;

  logic            inflight;
  occ_t            occ;
  logic            pop;
  logic            room;
  logic [LW-1:0]   level_next;

  fifo_prefetch_buf #(
    .DWIDTH (DWIDTH)
  ) u_buf (
    .clk       (clk_i),
    .srst_n    (srst_n_i),
    .push      (inflight),
    .push_data (fifo_data_i),
    .pop       (pop),
    .occ       (occ),
    .valid     (valid_o),
    .data      (data_o)
  );

  assign pop = valid_o & ready_i;

  // Room exists when buffered plus in-flight words leave a free slot
  assign room          = ({1'b0, occ} + {2'b00, inflight}) < 3'(PREFETCH_DEPTH);
  assign fifo_rd_req_o = srst_n_i & ~fifo_empty_i & room;

  // Total words held anywhere on the read path, wrapping at 2^LW
  assign level_next = LW'(fifo_usedw_i) + LW'(occ) + LW'(inflight);

  // Track the request whose data arrives next cycle, and register the level
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      inflight <= 1'b0;
      level_o  <= '0;
    end else begin
      inflight <= fifo_rd_req_o;
      level_o  <= level_next;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  // Count accepted beats and backpressured cycles, wrapping at 2^32
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      beat_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (pop) begin
        beat_cnt_o <= beat_cnt_o + 32'd1;
      end
      if (valid_o && !ready_i) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream_adapter
// Description : Scoreboard bench for fifo_rd_stream_adapter. A FIFO model
//               feeds words; expected words are queued on load and popped by
//               a monitor on every accepted beat. A count model (requested
//               minus delivered words) predicts request, valid and level.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream_adapter;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          srst_n_i;
  logic          fifo_empty_i;
  logic [AW-1:0] fifo_usedw_i;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_rd_req_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic [LW-1:0] level_o;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]   beat_cnt_o;
  logic [31:0]   stall_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int            outst    = 0;
  bit            last_req = 1'b0;
  logic [LW-1:0] lvl_pred = '0;
  int            beats_m  = 0;
  int            stalls_m = 0;

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(
    .DWIDTH (DW),
    .AWIDTH (AW)
  ) dut (
    .clk_i         (clk),
    .srst_n_i      (srst_n_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_usedw_i  (fifo_usedw_i),
    .fifo_data_i   (fifo_data_i),
    .fifo_rd_req_o (fifo_rd_req_o),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .level_o       (level_o)
`ifdef FIFO_RD_STREAM_STATS_EN
   ,.beat_cnt_o    (beat_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock cycle: check state after the last edge, then drive this cycle
  task automatic step(input bit rst_n, input bit rdy);
    int avail;
    bit exp_req;
    bit pop_m;
    @(negedge clk);
    avail = outst - int'(last_req);
    chk("level", 32'(level_o), 32'(lvl_pred));
    chk("valid", 32'(valid_o), 32'(avail > 0));
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("beat_cnt", beat_cnt_o, 32'(beats_m));
    chk("stall_cnt", stall_cnt_o, 32'(stalls_m));
`endif
    if (last_req) fifo_data_i = src_q.pop_front();
    else          fifo_data_i = DW'($urandom);
    srst_n_i     = rst_n;
    ready_i      = rdy;
    fifo_empty_i = (src_q.size() == 0);
    fifo_usedw_i = AW'(src_q.size());
    lvl_pred     = LW'(fifo_usedw_i) + LW'(outst);
    #1;
    exp_req = rst_n && !fifo_empty_i && (outst < 3);
    chk("rd_req", 32'(fifo_rd_req_o), 32'(exp_req));
    if (!rst_n) begin
      outst    = 0;
      last_req = 1'b0;
      src_q.delete();
      exp_q.delete();
      lvl_pred = '0;
      beats_m  = 0;
      stalls_m = 0;
    end else begin
      pop_m = (avail > 0) && rdy;
      if (pop_m) beats_m++;
      if ((avail > 0) && !rdy) stalls_m++;
      outst    = outst + int'(exp_req) - int'(pop_m);
      last_req = exp_req;
    end
  endtask

  // Monitor: every accepted beat must match the oldest expected word
  always @(negedge clk) begin
    #2;
    if (srst_n_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(data_o), 32'hFFFF_FFFF);
      end else begin
        chk("stream_data", 32'(data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int fed;
    int cyc;
    srst_n_i     = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_usedw_i = '0;
    fifo_data_i  = '0;
    ready_i      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_level", 32'(level_o), 32'h0);
    chk("rst_req", 32'(fifo_rd_req_o), 32'h0);

    // Empty FIFO: no requests, nothing presented
    for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom_range(0, 1)));

    // Three words, always ready
    load(8'h11); load(8'h22); load(8'h33);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    chk("three_drained", 32'(exp_q.size()), 32'h0);

    // Eight words under backpressure, then drain
    for (int i = 0; i < 8; i++) load(DW'($urandom));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    chk("bp_outstanding", 32'(outst), 32'd3);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin
      step(1'b1, 1'b1);
      cyc++;
    end
    chk("bp_drained", 32'(exp_q.size()), 32'h0);

    // Reset with two words buffered and one in flight
    for (int i = 0; i < 5; i++) load(DW'($urandom));
    cyc = 0;
    while (!(outst == 3 && last_req) && cyc < 10) begin
      step(1'b1, 1'b0);
      cyc++;
    end
    chk("pre_reset_state", 32'(outst == 3 && last_req), 32'h1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);

    // Randomized traffic: 1000 words, 50% ready
    fed = 0;
    cyc = 0;
    while ((fed < 1000 || exp_q.size() != 0) && cyc < 8000) begin
      if (fed < 1000 && src_q.size() < 12 && $urandom_range(0, 3) != 0) begin
        load(DW'($urandom));
        fed++;
      end
      step(1'b1, 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("random_fed", 32'(fed), 32'd1000);
    chk("random_drained", 32'(exp_q.size()), 32'h0);

    // Short directed pattern for the statistics path
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) load(DW'($urandom));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step(1'b1, 1'b1);
      cyc++;
    end
    step(1'b1, 1'b1);
    chk("stats_beats", 32'(beats_m), 32'd5);
    chk("stats_stalls", 32'(stalls_m), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
- Downstream consumer of the FIFO read-side pointer/empty logic, in the read clock domain.
- Converts the FIFO's request/empty interface (registered RAM read, 1-cycle latency) into a valid/ready stream.
- Uses a 3-entry prefetch buffer, so throughput is one beat per cycle with no combinational path from ready_i to fifo_rd_req_o.

Parameters:
- DWIDTH, 8, data word width.
- AWIDTH, 3, FIFO address width; sizes fifo_usedw_i.

Ports:
- clk_i  in  1  read-domain clock (same clock as the FIFO read side)
- srst_n_i  in  1  reset; synchronous, active-low
- fifo_empty_i  in  1  registered FIFO empty flag
- fifo_usedw_i  in  AWIDTH  FIFO fill level; informational, forwarded only
- fifo_data_i  in  DWIDTH  RAM read data; valid the cycle after an accepted request
- fifo_rd_req_o  out  1  read request to the FIFO
- data_o  out  DWIDTH  stream data (buffer head)
- valid_o  out  1  stream valid
- ready_i  in  1  stream ready
- level_o  out  AWIDTH+1  fifo_usedw_i + buffer occupancy + in-flight, registered

Behaviour:
- Reset (srst_n_i=0 at a clk_i edge):
  - occ=0, inflight=0, rd/wr pointers=0.
  - valid_o=0, data_o=0, level_o=0.
  - fifo_rd_req_o is forced 0 combinationally while srst_n_i=0.
- Buffer:
  - 3 entries, circular, 2-bit wr_ptr/rd_ptr, each wrapping 2->0.
  - occ counter 0..3.
- Request rule (combinational from registers only): fifo_rd_req_o = srst_n_i & ~fifo_empty_i & (occ + inflight < 3).
- In flight:
  - inflight <= fifo_rd_req_o, so it is 0 or 1.
  - When inflight=1, fifo_data_i is written at wr_ptr on that edge and wr_ptr advances.
- Pop: valid_o & ready_i; rd_ptr advances.
- valid_o = (occ != 0); data_o = buf[rd_ptr]. Both come from registers with no combinational input dependence.
- occ next = occ + inflight - pop:
  - push and pop in the same cycle leave occ unchanged;
  - push into occ=3 cannot occur, guaranteed by the request rule; the assertion must never fire.
- Latency: first word visible on data_o 2 cycles after fifo_empty_i falls (request at cycle n, capture at n+1, valid_o at n+2).
- Steady state: ready_i held 1 and FIFO non-empty gives 1 beat/cycle (occ=1, inflight=1).
- Empty boundary:
  - no request is issued while fifo_empty_i=1;
  - a word already in flight is still captured.
- Backpressure:
  - valid_o stays high and data_o is stable while ready_i=0;
  - requests stop once occ+inflight reaches 3.
- Reset mid-operation:
  - buffered and in-flight words are discarded;
  - the system resets the FIFO pointers in the same window.
- level_o is registered each cycle; width AWIDTH+1, wraps modulo 2^(AWIDTH+1), no saturation.

Optional Feature:
- Macro: FIFO_RD_STREAM_STATS_EN.
- Defined:
  - adds output beat_cnt_o (32) counting pops;
  - adds output stall_cnt_o (32) counting cycles with valid_o=1 & ready_i=0;
  - both reset to 0, wrap at 2^32.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package fifo_pkg holds:
  - localparam PREFETCH_DEPTH = 3 and PTR_W = 2;
  - typedef occ_t (logic [1:0]).
- One sub-module, fifo_prefetch_buf: the 3-entry circular storage with push/pop/occ.
- The top holds request/inflight logic, level_o and the optional counters.

Test Plan:
- Reset then FIFO empty for 10 cycles -> fifo_rd_req_o=0, valid_o=0, level_o=0 throughout.
- FIFO holds 0x11,0x22,0x33, ready_i=1 -> fifo_rd_req_o high 3 consecutive cycles; data_o shows 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after the first request; then valid_o=0.
- FIFO holds 8 words, ready_i=0 -> exactly 3 requests, occ=3, valid_o=1 with data_o=first word stable; raising ready_i then drains the remaining words in order at 1/cycle.
- Random ready_i (50%) over 1000 words -> output order equals input order, no loss or duplication, occ never exceeds 3.
- srst_n_i low for 1 cycle with occ=2, inflight=1 -> next cycle valid_o=0, occ=0; the in-flight word is not presented.
- FIFO_RD_STREAM_STATS_EN, 5 pops and 4 stall cycles -> beat_cnt_o=5, stall_cnt_o=4.
